// File: rtl/band_led_meter.sv
//------------------------------------------------------------------------------
// band_led_meter : per-band rectified peak meter driving one sigma-delta PDM LED
//                  per band; `LED_METER_HOLD_EN enables the peak-hold counter.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module band_led_meter #(
  parameter int NUM_BANDS    = 5,
  parameter int DATA_W       = 16,
  parameter int DECAY_SHIFT  = 3,
  parameter int HOLD_SAMPLES = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_BANDS*DATA_W-1:0]    band_data,
  input  logic                           band_vld,
  output logic [NUM_BANDS*(DATA_W-1)-1:0] peak,
  output logic [NUM_BANDS-1:0]           LED
);

  localparam int MW = DATA_W - 1;

  if (HOLD_SAMPLES < 0) begin : g_hold_range_check
    $error("HOLD_SAMPLES must be non-negative");
  end

  for (genvar k = 0; k < NUM_BANDS; k++) begin : g_band
    logic signed [DATA_W-1:0] sample;
    logic [DATA_W-1:0]        neg;
    logic [MW-1:0]            mag;
    logic [MW-1:0]            peak_r;
    logic [MW-1:0]            duty_r;
    logic [MW-1:0]            acc_r;
    logic [MW-1:0]            step;
    logic [MW-1:0]            decayed;
    logic [DATA_W-1:0]        sum;
    logic                     led_r;
    logic                     hold_active;

    assign sample = band_data[k*DATA_W +: DATA_W];
    assign neg    = -sample;

    // The most negative code has no positive twin, so it saturates.
    always_comb begin
      mag = sample[MW-1:0];
      if (sample[DATA_W-1]) begin
        if (sample[MW-1:0] == '0) mag = '1;
        else                      mag = neg[MW-1:0];
      end
    end

    always_comb begin
      step = peak_r >> DECAY_SHIFT;
      if (step == '0) step = MW'(1);
      decayed = (peak_r > step) ? (peak_r - step) : '0;
    end

`ifdef LED_METER_HOLD_EN
    localparam int HW = (HOLD_SAMPLES > 0) ? $clog2(HOLD_SAMPLES + 1) : 1;
    logic [HW-1:0] hold_r;

    always_ff @(posedge clk) begin
      if (rst) begin
        hold_r <= '0;
      end else if (band_vld) begin
        if (mag >= peak_r)      hold_r <= HW'(HOLD_SAMPLES);
        else if (hold_r != '0)  hold_r <= hold_r - HW'(1);
      end
    end

    assign hold_active = (hold_r != '0);
`else
    assign hold_active = 1'b0;
`endif

    always_ff @(posedge clk) begin
      if (rst) begin
        peak_r <= '0;
      end else if (band_vld) begin
        if (mag >= peak_r)   peak_r <= mag;
        else if (!hold_active) peak_r <= decayed;
      end
    end

    // Carry out of the MW-bit accumulator is the PDM bit; duty follows peak
    // one cycle late so the LED sees changes only on sample boundaries.
    assign sum = {1'b0, acc_r} + {1'b0, duty_r};

    always_ff @(posedge clk) begin
      if (rst) begin
        duty_r <= '0;
        acc_r  <= '0;
        led_r  <= 1'b0;
      end else begin
        duty_r <= peak_r;
        acc_r  <= sum[MW-1:0];
        led_r  <= sum[MW];
      end
    end

    assign peak[k*MW +: MW] = peak_r;
    assign LED[k]           = led_r;
  end

endmodule

`default_nettype wire

// File: tb/tb_band_led_meter.sv
//------------------------------------------------------------------------------
// tb_band_led_meter : directed self-checking bench for band_led_meter.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_band_led_meter;

  localparam int NB = 5;
  localparam int DW = 16;
  localparam int PW = DW - 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               band_vld;
  logic [NB*DW-1:0]   band_data;
  logic [NB*PW-1:0]   peak;
  logic [NB-1:0]      LED;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  band_led_meter #(
    .NUM_BANDS   (NB),
    .DATA_W      (DW),
    .DECAY_SHIFT (3),
    .HOLD_SAMPLES(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .band_data(band_data),
    .band_vld (band_vld),
    .peak     (peak),
    .LED      (LED)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int pk(input int k);
    return int'(peak[k*PW +: PW]);
  endfunction

  task automatic set_band(input int k, input int v);
    band_data[k*DW +: DW] = DW'(v);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe0(input int v);
    band_data = '0;
    set_band(0, v);
    band_vld = 1'b1;
    cyc();
    band_vld = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

`ifdef LED_METER_HOLD_EN
  int exp_dec[7]  = '{1000, 1000, 1000, 1000, 875, 766, 671};
  int exp_small[6] = '{5, 5, 5, 5, 4, 3};
  int exp_b2b     = 300;
`else
  int exp_dec[7]  = '{875, 766, 671, 588, 515, 451, 395};
  int exp_small[6] = '{4, 3, 2, 1, 0, 0};
  int exp_b2b     = 263;
`endif

  initial begin
    int cnt0;
    int cnt3;
    rst       = 1'b1;
    band_vld  = 1'b0;
    band_data = '0;
    cyc();
    cyc();
    rst = 1'b0;

    for (int k = 0; k < NB; k++) check($sformatf("reset_peak%0d", k), pk(k), 0);
    check("reset_led", int'(LED), 0);

    // Rectification and saturation of the most negative code
    band_data = '0;
    set_band(0, -32768);
    set_band(1, -1000);
    set_band(2, 1000);
    band_vld = 1'b1;
    cyc();
    band_vld = 1'b0;
    check("rect_peak0", pk(0), 32767);
    check("rect_peak1", pk(1), 1000);
    check("rect_peak2", pk(2), 1000);
    check("rect_peak3", pk(3), 0);
    do_reset();
    check("rst_clear_peak0", pk(0), 0);

    // Decay (immediate, or after the hold window when hold is built in)
    strobe0(1000);
    check("dec_load", pk(0), 1000);
    for (int i = 0; i < 7; i++) begin
      strobe0(0);
      check($sformatf("dec_step%0d", i), pk(0), exp_dec[i]);
    end

    do_reset();
    strobe0(5);
    check("small_load", pk(0), 5);
    for (int i = 0; i < 6; i++) begin
      strobe0(0);
      check($sformatf("small_step%0d", i), pk(0), exp_small[i]);
    end

    // Back-to-back strobes
    do_reset();
    band_data = '0;
    set_band(0, 100);
    band_vld = 1'b1;
    cyc();
    check("b2b_0", pk(0), 100);
    set_band(0, 300);
    cyc();
    check("b2b_1", pk(0), 300);
    set_band(0, 200);
    cyc();
    check("b2b_2", pk(0), exp_b2b);
    band_vld = 1'b0;

    // Reset and strobe together: sample is dropped
    set_band(0, 5000);
    band_vld = 1'b1;
    rst      = 1'b1;
    cyc();
    rst      = 1'b0;
    band_vld = 1'b0;
    check("rst_vld_drop", pk(0), 0);
    cyc();
    check("rst_vld_drop_hold", pk(0), 0);

    // PDM density at quarter scale
    band_data = '0;
    set_band(3, 8192);
    band_vld = 1'b1;
    cyc();
    band_vld = 1'b0;
    check("pdm_peak3", pk(3), 8192);
    repeat (8) cyc();
    cnt0 = 0;
    cnt3 = 0;
    for (int i = 0; i < 1024; i++) begin
      cnt0 += int'(LED[0]);
      cnt3 += int'(LED[3]);
      cyc();
    end
    check("pdm_quarter_highs", cnt3, 256);
    check("pdm_zero_highs", cnt0, 0);

    // PDM density at full scale
    band_data = '0;
    set_band(3, 32767);
    band_vld = 1'b1;
    cyc();
    band_vld = 1'b0;
    check("pdm_peak3_max", pk(3), 32767);
    repeat (8) cyc();
    cnt3 = 0;
    for (int i = 0; i < 1024; i++) begin
      cnt3 += int'(LED[3]);
      cyc();
    end
    check("pdm_max_ge1023", int'(cnt3 >= 1023), 1);

    // Reset mid-stream with a large peak
    do_reset();
    strobe0(20000);
    check("mid_peak", pk(0), 20000);
    repeat (3) cyc();
    do_reset();
    for (int k = 0; k < NB; k++) check($sformatf("mid_rst_peak%0d", k), pk(k), 0);
    check("mid_rst_led", int'(LED), 0);
    cnt0 = 0;
    for (int i = 0; i < 64; i++) begin
      if (LED != '0) cnt0++;
      cyc();
    end
    check("mid_rst_led_quiet", cnt0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
